// File: rtl/fetch_stage_pkg.sv
// Shared processor definitions for the fetch stage: FSM encoding, reset PC and
// PC alignment helper.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold,
    StDrop
  } fetch_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid flag plus instruction and PC+4 payload.
// Clear has priority over load; with neither asserted, contents are held.
module if_id_reg (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem read, one-entry hold buffer for
// words returning while decode stalls, and redirect handling with stale-ack drop.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc4,
  output logic [31:0]       fetch_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc4_q, hold_pc4_d;
  logic [31:0]  pc_plus4;
  logic         id_load, id_clear;
  logic [31:0]  id_instr_d, id_pc4_d;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    id_load      = 1'b0;
    id_clear     = 1'b0;
    id_instr_d   = imem_rdata;
    id_pc4_d     = pc_plus4;
    imem_req     = 1'b0;

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        imem_req = 1'b1;
        if (redirect) begin
          // Without an ack the read is still in flight and its word must be dropped.
          state_d = imem_ack ? StReq : StDrop;
        end else if (imem_ack) begin
          pc_d = pc_plus4;
          if (!stall || !id_valid) begin
            id_load = 1'b1;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc4_d   = pc_plus4;
            state_d      = StHold;
          end
        end
      end
      StHold: begin
        if (redirect) begin
          state_d = StReq;
        end else if (!stall) begin
          id_load    = 1'b1;
          id_instr_d = hold_instr_q;
          id_pc4_d   = hold_pc4_q;
          state_d    = StReq;
        end
      end
      StDrop: begin
        // A redirect coinciding with the stale ack still consumes that ack.
        if (imem_ack) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase

    if (redirect) begin
      pc_d         = align_pc(redirect_pc);
      hold_instr_d = 32'd0;
      hold_pc4_d   = 32'd0;
      id_clear     = 1'b1;
    end else if (!id_load && !stall) begin
      id_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      hold_instr_q <= 32'd0;
      hold_pc4_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (id_load),
    .clear_i (id_clear),
    .instr_i (id_instr_d),
    .pc4_i   (id_pc4_d),
    .valid_o (id_valid),
    .instr_o (id_instr),
    .pc4_o   (id_pc4)
  );

  assign imem_addr = pc_q[ADDR_W-1:0];
  assign fetch_pc  = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage; checks the instruction stream
// seen by decode against the expected sequential/redirected program order.
module tb_fetch_stage;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              stall = 1'b0;
  logic              redirect = 1'b0;
  logic [31:0]       redirect_pc = 32'd0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              id_valid;
  logic [31:0]       id_instr, id_pc4, fetch_pc;

  logic              w_req;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_rdata;
  logic              w_valid;
  logic [31:0]       w_instr, w_pc4, w_pc;

  int errors = 0;
  int checks = 0;

  // Memory model state: latency applies to reads accepted from now on.
  int              lat = 0;
  bit              outstanding = 1'b0;
  int              cnt = 0;
  logic [ADDR_W-1:0] o_addr = '0;

  // Stream model state.
  logic [31:0] exp_next = 32'd0;
  int          idle_run = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [ADDR_W-1:0] a);
    return {6'h2A, a, ~a, 6'h15};
  endfunction

  assign imem_ack   = outstanding ? (cnt == 0) : (imem_req && lat == 0);
  assign imem_rdata = word(outstanding ? o_addr : imem_addr);
  assign w_rdata    = word(w_addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= 1'b0;
      cnt         <= 0;
      o_addr      <= '0;
    end else if (imem_ack) begin
      outstanding <= 1'b0;
    end else if (outstanding) begin
      cnt <= cnt - 1;
    end else if (imem_req) begin
      outstanding <= 1'b1;
      cnt         <= lat - 1;
      o_addr      <= imem_addr;
    end
  end

  fetch_stage #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc4      (id_pc4),
    .fetch_pc    (fetch_pc)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .ADDR_W(ADDR_W)) u_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_ack    (w_req),
    .imem_rdata  (w_rdata),
    .id_valid    (w_valid),
    .id_instr    (w_instr),
    .id_pc4      (w_pc4),
    .fetch_pc    (w_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after a falling edge, sample just before the rising
  // edge, then check the result at the next falling edge.
  task automatic cycle(input logic s, input logic r, input logic [31:0] t);
    logic        p_valid;
    logic [31:0] p_instr, p_pc4, tgt;
    stall       = s;
    redirect    = r;
    redirect_pc = t;
    #4;
    p_valid = id_valid;
    p_instr = id_instr;
    p_pc4   = id_pc4;
    @(negedge clk);
    chk("addr_map", 32'(imem_addr), 32'(fetch_pc[ADDR_W-1:0]));
    if (r) begin
      tgt = {t[31:2], 2'b00};
      chk("redir_valid", 32'(id_valid), 32'd0);
      chk("redir_pc", fetch_pc, tgt);
      exp_next = tgt;
      idle_run = 0;
    end else if (p_valid && !s) begin
      chk("deliver_pc4", p_pc4, exp_next + 32'd4);
      chk("deliver_instr", p_instr, word(exp_next[ADDR_W-1:0]));
      exp_next = exp_next + 32'd4;
      idle_run = 0;
    end else begin
      if (p_valid) begin
        chk("freeze_valid", 32'(id_valid), 32'd1);
        chk("freeze_pc4", id_pc4, p_pc4);
        chk("freeze_instr", id_instr, p_instr);
      end
      if (!s) idle_run++;
      chk("progress", 32'(idle_run > 12), 32'd0);
      if (idle_run > 12) idle_run = 0;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_pc4", id_pc4, 32'd0);
    chk("rst_pc", fetch_pc, 32'd0);
    chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
    rst_n = 1'b1;
    chk("idle_req", 32'(imem_req), 32'd0);

    // Zero-latency back-to-back fetch, plus wrap instance
    cycle(1'b0, 1'b0, 32'd0);
    chk("f0_req", 32'(imem_req), 32'd1);
    chk("f0_addr", 32'(imem_addr), 32'h000);
    chk("wrap_addr0", 32'(w_addr), 32'h3FC);
    cycle(1'b0, 1'b0, 32'd0);
    chk("f1_addr", 32'(imem_addr), 32'h004);
    chk("f1_pc4", id_pc4, 32'h4);
    chk("wrap_pc1", w_pc, 32'h0);
    chk("wrap_addr1", 32'(w_addr), 32'h000);
    chk("wrap_pc4", w_pc4, 32'h0);
    chk("wrap_instr", w_instr, word(10'h3FC));
    cycle(1'b0, 1'b0, 32'd0);
    chk("f2_addr", 32'(imem_addr), 32'h008);
    chk("f2_pc4", id_pc4, 32'h8);
    cycle(1'b0, 1'b0, 32'd0);
    chk("f3_pc4", id_pc4, 32'hC);

    // Two-cycle latency: one word every third cycle
    lat = 2;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 32'd0);
      chk("lat2_valid", 32'(id_valid), 32'((i % 3) == 2));
    end
    chk("lat2_pc4", id_pc4, 32'h14);

    // Stall three cycles while the ack arrives: word parks in the hold buffer
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'd0);
      chk("stall_pc4", id_pc4, 32'h14);
    end
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_pc", fetch_pc, 32'h18);
    cycle(1'b0, 1'b0, 32'd0);
    chk("unhold_valid", 32'(id_valid), 32'd1);
    chk("unhold_pc4", id_pc4, 32'h18);
    chk("unhold_req", 32'(imem_req), 32'd1);

    // Redirect with a read in flight: stale word dropped, fetch resumes at 0x100
    lat = 3;
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'h0000_0102);
    chk("drop_req", 32'(imem_req), 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    chk("drop_valid0", 32'(id_valid), 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    chk("drop_valid1", 32'(id_valid), 32'd0);
    chk("drop_addr", 32'(imem_addr), 32'h100);
    chk("drop_resume", 32'(imem_req), 32'd1);
    repeat (4) cycle(1'b0, 1'b0, 32'd0);
    chk("tgt_valid", 32'(id_valid), 32'd1);
    chk("tgt_pc4", id_pc4, 32'h104);

    // Redirect, stall and ack together
    lat = 0;
    cycle(1'b1, 1'b1, 32'h0000_0200);
    chk("rsa_req", 32'(imem_req), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      lat = int'($urandom_range(0, 3));
      cycle(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 15) == 0), $urandom);
    end

    // Reset mid-request
    lat = 2;
    cycle(1'b0, 1'b1, 32'h0000_0040);
    cycle(1'b0, 1'b0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_req", 32'(imem_req), 32'd0);
    chk("mrst_valid", 32'(id_valid), 32'd0);
    chk("mrst_instr", id_instr, 32'd0);
    chk("mrst_pc4", id_pc4, 32'd0);
    chk("mrst_pc", fetch_pc, 32'd0);
    exp_next = 32'd0;
    idle_run = 0;
    @(negedge clk);
    rst_n = 1'b1;
    lat   = 0;
    cycle(1'b0, 1'b0, 32'd0);
    chk("post_addr", 32'(imem_addr), 32'h000);
    cycle(1'b0, 1'b0, 32'd0);
    chk("post_pc4", id_pc4, 32'h4);
    repeat (3) cycle(1'b0, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter ADDR_W, default 10, SHALL be the instruction-memory byte-address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 stall  input  1  SHALL mean decode cannot accept; hold IF/ID contents.
REQ-006 redirect  input  1  SHALL mean a taken branch or jump from execute.
REQ-007 redirect_pc  input  32  SHALL be the branch/jump target.
REQ-008 imem_req  output  1  SHALL be the read request to instruction memory.
REQ-009 imem_addr  output  ADDR_W  SHALL be the byte address, equal to pc[ADDR_W-1:0].
REQ-010 imem_ack  input  1  SHALL mark imem_rdata valid; any latency of at least 0 cycles; one outstanding read.
REQ-011 imem_rdata  input  32  SHALL be the instruction word.
REQ-012 id_valid / id_instr / id_pc4  output  1/32/32  SHALL be the IF/ID register: valid flag, instruction, fetch PC+4.
REQ-013 fetch_pc  output  32  SHALL be the current fetch PC.

Function
REQ-014 FSM states SHALL be IDLE, REQ, HOLD and DROP; imem_req=1 only in REQ.
REQ-015 IDLE→REQ SHALL occur on the first clock edge after rst_n deasserts.
REQ-016 An ack in REQ is accepted when redirect=0; on acceptance pc SHALL become pc+4, modulo 2^32.
REQ-017 Accepted ack with stall=0 or id_valid=0 SHALL load IF/ID: id_valid=1, id_instr=imem_rdata, id_pc4=pc+4. State stays REQ.
REQ-018 Accepted ack with stall=1 and id_valid=1 SHALL capture the word and pc+4 into a one-entry hold buffer. State→HOLD.
REQ-019 HOLD with stall=0 SHALL move the buffer into IF/ID. State→REQ. A new request SHALL issue the next cycle.
REQ-020 Cycles with stall=0 and no word delivered SHALL set id_valid=0 (bubble).
REQ-021 stall=1 with id_valid=1 SHALL freeze id_instr, id_pc4 and id_valid.
REQ-022 redirect=1 SHALL take priority over stall, ack and hold.
REQ-023 On redirect, pc SHALL become {redirect_pc[31:2],2'b00}; id_valid and the hold buffer SHALL be cleared next cycle.
REQ-024 Redirect in REQ without ack SHALL go to DROP. Redirect in REQ with ack, or in HOLD, SHALL discard the word and go to REQ.
REQ-025 In DROP, the next ack SHALL be discarded, then state→REQ. A further redirect in DROP SHALL update pc and stay in DROP.
REQ-026 Same-cycle redirect and stall SHALL flush, not hold.
REQ-027 imem_addr SHALL wrap with pc's low ADDR_W bits; no out-of-range error.

Reset
REQ-028 While rst_n=0: state=IDLE, pc=RESET_PC, imem_req=0, id_valid=0, id_instr=0, id_pc4=0, hold buffer empty.
REQ-029 Asserting rst_n mid-request SHALL drop the request immediately. A late ack after reset SHALL be ignored until REQ is entered.

Structure
REQ-030 The FSM state encoding and the RESET_PC default SHALL live in the shared processor package.
REQ-031 The IF/ID register with valid, load and clear SHALL be one sub-module, if_id_reg. The FSM, pc and hold buffer stay in fetch_stage.

Verification
REQ-032 Reset, then 0-latency ack, stall=0. Expect: fetch addresses 0x000, 0x004, 0x008 on consecutive cycles; id_pc4 = 0x4, 0x8, 0xC.
REQ-033 Ack latency 2 cycles. Expect: id_valid toggles 1,0,0 per word; no address skipped or repeated.
REQ-034 stall=1 for 3 cycles with id_valid=1, ack arriving during the stall. Expect: id_instr frozen; HOLD entered; buffered word appears the cycle after stall falls; no request issued during HOLD.
REQ-035 redirect to 0x0000_0102 while an ack is pending (latency 3). Expect: DROP entered; stale word never sets id_valid; next fetch address 0x100.
REQ-036 redirect, stall and ack in the same cycle. Expect: id_valid=0 next cycle; pc=redirect target.
REQ-037 RESET_PC=0xFFFF_FFFC. Expect: second fetch pc wraps to 0x0000_0000; imem_addr = 0x3FC then 0x000.
